// File: rtl/peri_fifo8_ctrl.sv
// Byte FIFO controller: owns a 1-cycle-latency simple dual-port RAM and presents
// a first-word-fall-through valid/ack pop port with a two-entry output stage.
module peri_fifo8_ctrl #(
  parameter int CAddrBits = 8,
  parameter int CDataBits = 8
) (
  input  logic                   AClkH,
  input  logic                   AResetH,
  input  logic                   AClear,
  input  logic [CDataBits-1:0]   APushData,
  input  logic                   APushEn,
  output logic                   AFull,
  output logic [CDataBits-1:0]   APopData,
  output logic                   APopValid,
  input  logic                   APopAck,
  output logic [CAddrBits+1:0]   ACount,
  output logic                   AEmpty,
  output logic                   AOverflow,
  output logic                   AUnderflow,
  output logic [CAddrBits-1:0]   ARamAddrWr,
  output logic [CDataBits-1:0]   ARamMosi,
  output logic                   ARamWrEn,
  output logic [CAddrBits-1:0]   ARamAddrRd,
  input  logic [CDataBits-1:0]   ARamMiso
);

  localparam logic [CAddrBits:0] CDepth = {1'b1, {CAddrBits{1'b0}}};

  logic [CAddrBits-1:0] wr_ptr_q,  wr_ptr_d;
  logic [CAddrBits-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CAddrBits:0]   ram_cnt_q, ram_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [CDataBits-1:0] out_q,     out_d;
  logic                 o_vld_q,   o_vld_d;
  logic [CDataBits-1:0] skid_q,    skid_d;
  logic                 s_vld_q,   s_vld_d;
  logic                 ovf_q,     ovf_d;
  logic                 udf_q,     udf_d;

  logic       wr_en;
  logic       pop;
  logic       issue;
  logic [1:0] occ;

  assign AFull      = (ram_cnt_q == CDepth);
  assign wr_en      = APushEn & ~AFull & ~AResetH & ~AClear;
  assign ARamWrEn   = wr_en;
  assign ARamAddrWr = wr_ptr_q;
  assign ARamMosi   = APushData;
  assign ARamAddrRd = rd_ptr_q;

  assign pop   = APopAck & o_vld_q;
  assign occ   = {1'b0, o_vld_q} + {1'b0, s_vld_q} + {1'b0, rd_pend_q} - {1'b0, pop};
  // RamCnt excludes same-cycle writes, so a read never targets the word being written.
  assign issue = (ram_cnt_q != '0) && (occ < 2'd2);

  assign ACount     = (CAddrBits+2)'(ram_cnt_q) + (CAddrBits+2)'(rd_pend_q)
                    + (CAddrBits+2)'(o_vld_q)   + (CAddrBits+2)'(s_vld_q);
  assign AEmpty     = (ACount == '0);
  assign APopValid  = o_vld_q;
  assign APopData   = out_q;
  assign AOverflow  = ovf_q;
  assign AUnderflow = udf_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + CAddrBits'(wr_en);
    rd_ptr_d  = rd_ptr_q + CAddrBits'(issue);
    ram_cnt_d = ram_cnt_q + (CAddrBits+1)'(wr_en) - (CAddrBits+1)'(issue);
    rd_pend_d = issue;
    out_d     = out_q;
    o_vld_d   = o_vld_q;
    skid_d    = skid_q;
    s_vld_d   = s_vld_q;
    ovf_d     = ovf_q | (APushEn & AFull);
    udf_d     = udf_q | (APopAck & ~o_vld_q);

    // Age order: OutReg, then SkidReg, then the word landing from the RAM.
    if (pop) begin
      if (s_vld_q) begin
        out_d   = skid_q;
        s_vld_d = rd_pend_q;
        if (rd_pend_q) skid_d = ARamMiso;
      end else begin
        o_vld_d = rd_pend_q;
        if (rd_pend_q) out_d = ARamMiso;
      end
    end else if (rd_pend_q) begin
      if (!o_vld_q) begin
        out_d   = ARamMiso;
        o_vld_d = 1'b1;
      end else begin
        skid_d  = ARamMiso;
        s_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge AClkH) begin
    if (AResetH || AClear) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      out_q     <= '0;
      o_vld_q   <= 1'b0;
      skid_q    <= '0;
      s_vld_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      out_q     <= out_d;
      o_vld_q   <= o_vld_d;
      skid_q    <= skid_d;
      s_vld_q   <= s_vld_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

endmodule

// File: tb/tb_peri_fifo8_ctrl.sv
// Bench for peri_fifo8_ctrl: behavioural RAM, queue-based reference model,
// directed scenarios followed by a randomized push/pop phase.
module tb_peri_fifo8_ctrl;

  localparam int MAXC = 258;

  logic       clk = 1'b0;
  logic       rst, clr, push, ack;
  logic [7:0] pdata;
  logic       full, pv, empty, ovf, udf, wen;
  logic [7:0] popd, wa, wd, ra, miso;
  logic [9:0] cnt;

  always #5 clk = ~clk;

  peri_fifo8_ctrl #(.CAddrBits(8), .CDataBits(8)) dut (
    .AClkH(clk), .AResetH(rst), .AClear(clr),
    .APushData(pdata), .APushEn(push), .AFull(full),
    .APopData(popd), .APopValid(pv), .APopAck(ack),
    .ACount(cnt), .AEmpty(empty), .AOverflow(ovf), .AUnderflow(udf),
    .ARamAddrWr(wa), .ARamMosi(wd), .ARamWrEn(wen),
    .ARamAddrRd(ra), .ARamMiso(miso)
  );

  // 256x8 RAM, registered read, read-first on collision
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (wen) mem[wa] <= wd;
    miso <= mem[ra];
  end

  logic [7:0] q[$];
  int  wr_idx;
  bit  m_ovf, m_udf;
  int  exp_pv;
  bit  warm;
  bit  skid_seen;
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ewen, popping;
    #2;
    ewen = push && (q.size() != MAXC) && !rst && !clr;
    chk("wr_en", wen, ewen);
    if (ewen) begin
      chk("wr_addr", wa, wr_idx & 255);
      chk("wr_data", wd, pdata);
    end
    if (warm) begin
      chk("count", cnt, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == MAXC);
      chk("overflow", ovf, m_ovf);
      chk("underflow", udf, m_udf);
      if (exp_pv >= 0) chk("pop_valid", pv, exp_pv);
      if (ack && pv === 1'b1 && q.size() > 0) chk("pop_data", popd, q[0]);
    end
    popping = ack && (pv === 1'b1);
    @(posedge clk);
    if (rst || clr) begin
      q.delete();
      wr_idx = 0;
      m_ovf  = 0;
      m_udf  = 0;
    end else begin
      if (push && q.size() == MAXC) m_ovf = 1;
      if (ack && q.size() == 0) m_udf = 1;
      if (popping && q.size() > 0) void'(q.pop_front());
      if (ewen) begin
        q.push_back(pdata);
        wr_idx++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; clr = 0; push = 1; pdata = 8'h55; ack = 0; exp_pv = -1;
    tick();
    warm = 1;
    tick();
    rst = 0; push = 0;
    exp_pv = 0;
    tick();
    chk("rst_popdata", popd, 8'h00);
    exp_pv = -1;
  endtask

  task automatic idle(input int n);
    push = 0; ack = 0;
    repeat (n) tick();
  endtask

  task automatic drain(input int bound);
    push = 0;
    for (int i = 0; i < bound && q.size() > 0; i++) begin
      ack = pv;
      tick();
    end
    ack = 0;
    chk("drain_done", cnt, 0);
  endtask

  initial begin
    warm = 0;
    do_reset();

    // latency: push in cycle N, valid in N+3
    push = 1; pdata = 8'hA5; exp_pv = 0; tick();
    push = 0; tick(); tick();
    exp_pv = 1; ack = 1; tick();
    ack = 0; exp_pv = -1; tick();
    chk("lat_empty", empty, 1);

    // fill to 258, overflow push, ordered drain
    do_reset();
    for (int i = 0; i < MAXC; i++) begin
      push = 1; pdata = 8'(i); tick();
    end
    push = 1; pdata = 8'h77; tick();
    push = 0; tick();
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 1);
    chk("fill_count", cnt, 258);
    drain(800);

    // streaming across two pointer wraps
    do_reset();
    for (int t = 0; t < 603; t++) begin
      push = (t < 600); pdata = 8'(t); ack = (t >= 3);
      exp_pv = (t >= 3) ? 1 : 0;
      tick();
    end
    ack = 0; push = 0; exp_pv = -1;
    tick();

    // backpressure: ack one cycle in three
    do_reset();
    skid_seen = 0;
    for (int t = 0; t < 300; t++) begin
      push = 1; pdata = 8'($urandom); ack = (t % 3 == 0) && pv;
      tick();
      if (dut.s_vld_q === 1'b1) skid_seen = 1;
    end
    drain(800);
    chk("skid_seen", skid_seen, 1);

    // clear with a read in flight
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push = 1; pdata = 8'(8'h10 + i); tick();
    end
    idle(4);
    ack = pv; tick();
    ack = 0;
    chk("clr_pre_count", cnt, 5);
    chk("clr_pre_rdpend", dut.rd_pend_q, 1);
    clr = 1; tick();
    clr = 0; exp_pv = 0;
    repeat (3) tick();
    push = 1; pdata = 8'h3C; tick();
    push = 0; exp_pv = -1;
    drain(20);

    // underflow
    idle(4);
    ack = 1; exp_pv = 0; tick();
    ack = 0; tick();
    chk("udf_flag", udf, 1);
    chk("udf_count", cnt, 0);
    exp_pv = -1;

    // randomized phase
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      push = 1'($urandom_range(0, 1));
      pdata = 8'($urandom);
      ack = pv & 1'($urandom_range(0, 1));
      tick();
    end
    drain(800);
    exp_pv = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
